// File: rtl/read_bpm_test_link_pkg.sv
// Shared definitions for the BPM test link: header field layout, magic value,
// status codes and receive FSM states.
package read_bpm_test_link_pkg;
  localparam int          DEF_MAGIC_WIDTH     = 16;
  localparam int          DEF_MAGIC_START_BIT = 16;
  localparam int          DEF_INDEX_WIDTH     = 5;
  localparam int          DEF_INDEX_START_BIT = 10;
  localparam int          DEF_NUM_DATA_WORDS  = 3;
  localparam int          DEF_CNT_WIDTH       = 16;
  localparam logic [15:0] DEF_HEADER_MAGIC    = 16'hA5BE;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_BAD_MAGIC = 2'd1;
  localparam logic [1:0] ST_SHORT     = 2'd2;
  localparam logic [1:0] ST_LONG      = 2'd3;

  typedef enum logic [1:0] {S_HEADER, S_DATA, S_DISCARD} rx_state_t;
endpackage

// File: rtl/read_bpm_test_link_sat_counter.sv
// Saturating up-counter; sticks at all-ones.
module read_bpm_test_link_sat_counter
  import read_bpm_test_link_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      r_cnt <= '0;
    else if (i_inc && r_cnt != '1)  r_cnt <= r_cnt + CNT_WIDTH'(1);
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/read_bpm_test_link.sv
// Receive end of the BPM test link: validates header/length of Aurora stream packets,
// strobes out good packets, counts errors and tracks per-FA-cycle received indices.
module read_bpm_test_link
  import read_bpm_test_link_pkg::*;
#(
  parameter int                     MAGIC_WIDTH     = DEF_MAGIC_WIDTH,
  parameter int                     MAGIC_START_BIT = DEF_MAGIC_START_BIT,
  parameter int                     INDEX_WIDTH     = DEF_INDEX_WIDTH,
  parameter int                     INDEX_START_BIT = DEF_INDEX_START_BIT,
  parameter int                     NUM_DATA_WORDS  = DEF_NUM_DATA_WORDS,
  parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC    = MAGIC_WIDTH'(DEF_HEADER_MAGIC),
  parameter int                     CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                           auroraUserClk,
  input  logic                           auroraReset,
  input  logic                           auroraChannelUp,
  input  logic                           auroraFAstrobe,
  input  logic [31:0]                    BPM_TEST_AXI_STREAM_RX_tdata,
  input  logic                           BPM_TEST_AXI_STREAM_RX_tvalid,
  input  logic                           BPM_TEST_AXI_STREAM_RX_tlast,
  output logic                           BPM_TEST_AXI_STREAM_RX_tready,
  output logic                           packetStrobe,
  output logic [INDEX_WIDTH-1:0]         packetIndex,
  output logic [32*NUM_DATA_WORDS-1:0]   packetData,
  output logic                           statusStrobe,
  output logic [1:0]                     statusCode,
  output logic [CNT_WIDTH-1:0]           packetCount,
  output logic [CNT_WIDTH-1:0]           badMagicCount,
  output logic [CNT_WIDTH-1:0]           badSizeCount,
  output logic [2**INDEX_WIDTH-1:0]      indexBitmap
);
  localparam int              WC_W    = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
  localparam int              BM_W    = 2**INDEX_WIDTH;
  localparam logic [WC_W-1:0] LAST_WC = WC_W'(NUM_DATA_WORDS-1);

  rx_state_t                         r_state, w_nState;
  logic [WC_W-1:0]                   r_wcnt, w_wcntNext;
  logic [INDEX_WIDTH-1:0]            r_idx, r_pktIdx;
  logic [NUM_DATA_WORDS-1:0][31:0]   r_buf, r_pktData, w_pktData;
  logic                              r_pktStb, r_statStb;
  logic [1:0]                        r_statCode, w_code;
  logic [BM_W-1:0]                   r_acc, r_bitmap, w_accNext;
  logic                              w_beat, w_magicOk, w_evt, w_good, w_hdrLatch, w_store;
  logic [31:0]                       w_d;

  assign w_d       = BPM_TEST_AXI_STREAM_RX_tdata;
  assign w_beat    = BPM_TEST_AXI_STREAM_RX_tvalid & auroraChannelUp;
  assign w_magicOk = (w_d[MAGIC_START_BIT +: MAGIC_WIDTH] == HEADER_MAGIC);

  always_comb begin
    w_nState   = r_state;
    w_wcntNext = r_wcnt;
    w_evt      = 1'b0;
    w_code     = ST_OK;
    w_good     = 1'b0;
    w_hdrLatch = 1'b0;
    w_store    = 1'b0;
    if (!auroraChannelUp) begin
      // Link loss abandons any partial packet without reporting it.
      w_nState = S_HEADER;
    end else if (w_beat) begin
      case (r_state)
        S_HEADER: begin
          if (w_magicOk) begin
            if (BPM_TEST_AXI_STREAM_RX_tlast) begin
              w_evt  = 1'b1;
              w_code = ST_SHORT;
            end else begin
              w_nState   = S_DATA;
              w_wcntNext = '0;
              w_hdrLatch = 1'b1;
            end
          end else begin
            w_evt  = 1'b1;
            w_code = ST_BAD_MAGIC;
            if (!BPM_TEST_AXI_STREAM_RX_tlast) w_nState = S_DISCARD;
          end
        end
        S_DATA: begin
          w_store    = 1'b1;
          w_wcntNext = r_wcnt + WC_W'(1);
          if (r_wcnt == LAST_WC) begin
            w_evt = 1'b1;
            if (BPM_TEST_AXI_STREAM_RX_tlast) begin
              w_good   = 1'b1;
              w_code   = ST_OK;
              w_nState = S_HEADER;
            end else begin
              w_code   = ST_LONG;
              w_nState = S_DISCARD;
            end
          end else if (BPM_TEST_AXI_STREAM_RX_tlast) begin
            w_evt    = 1'b1;
            w_code   = ST_SHORT;
            w_nState = S_HEADER;
          end
        end
        S_DISCARD: if (BPM_TEST_AXI_STREAM_RX_tlast) w_nState = S_HEADER;
        default:   w_nState = S_HEADER;
      endcase
    end
  end

  // Final data word goes straight from the bus into the output register.
  always_comb begin
    w_pktData                   = r_buf;
    w_pktData[NUM_DATA_WORDS-1] = w_d;
  end

  assign w_accNext = r_acc | (w_good ? (BM_W'(1) << r_idx) : '0);

  always_ff @(posedge auroraUserClk or posedge auroraReset) begin
    if (auroraReset) begin
      r_state    <= S_HEADER;
      r_wcnt     <= '0;
      r_idx      <= '0;
      r_buf      <= '0;
      r_pktData  <= '0;
      r_pktIdx   <= '0;
      r_pktStb   <= 1'b0;
      r_statStb  <= 1'b0;
      r_statCode <= ST_OK;
      r_acc      <= '0;
      r_bitmap   <= '0;
    end else begin
      r_state   <= w_nState;
      r_wcnt    <= w_wcntNext;
      r_pktStb  <= w_good;
      r_statStb <= w_evt;
      if (w_hdrLatch) r_idx <= w_d[INDEX_START_BIT +: INDEX_WIDTH];
      if (w_store)    r_buf[r_wcnt] <= w_d;
      if (w_evt)      r_statCode <= w_code;
      if (w_good) begin
        r_pktData <= w_pktData;
        r_pktIdx  <= r_idx;
      end
      if (auroraFAstrobe) begin
        r_bitmap <= w_accNext;
        r_acc    <= '0;
      end else begin
        r_acc    <= w_accNext;
      end
    end
  end

  read_bpm_test_link_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_pkt (
    .i_clk(auroraUserClk), .i_rst(auroraReset),
    .i_inc(w_evt && w_code == ST_OK), .o_cnt(packetCount));
  read_bpm_test_link_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_magic (
    .i_clk(auroraUserClk), .i_rst(auroraReset),
    .i_inc(w_evt && w_code == ST_BAD_MAGIC), .o_cnt(badMagicCount));
  read_bpm_test_link_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_size (
    .i_clk(auroraUserClk), .i_rst(auroraReset),
    .i_inc(w_evt && (w_code == ST_SHORT || w_code == ST_LONG)), .o_cnt(badSizeCount));

  assign BPM_TEST_AXI_STREAM_RX_tready = auroraChannelUp;
  assign packetStrobe = r_pktStb;
  assign packetIndex  = r_pktIdx;
  assign packetData   = r_pktData;
  assign statusStrobe = r_statStb;
  assign statusCode   = r_statCode;
  assign indexBitmap  = r_bitmap;
endmodule

// File: tb/tb_read_bpm_test_link.sv
// Directed bench for read_bpm_test_link: packet vector table plus hand-written
// sequences for FA bitmap, random tvalid gaps and link drop.
module tb_read_bpm_test_link;
  logic        clk = 1'b0;
  logic        rst, chUp, fa, tvalid, tlast, tready;
  logic [31:0] tdata;
  logic        pStb, sStb;
  logic [4:0]  pIdx;
  logic [95:0] pData;
  logic [1:0]  sCode;
  logic [15:0] cPkt, cMag, cSize;
  logic [31:0] bmap;

  always #5 clk = ~clk;

  read_bpm_test_link dut (
    .auroraUserClk(clk), .auroraReset(rst), .auroraChannelUp(chUp), .auroraFAstrobe(fa),
    .BPM_TEST_AXI_STREAM_RX_tdata(tdata), .BPM_TEST_AXI_STREAM_RX_tvalid(tvalid),
    .BPM_TEST_AXI_STREAM_RX_tlast(tlast), .BPM_TEST_AXI_STREAM_RX_tready(tready),
    .packetStrobe(pStb), .packetIndex(pIdx), .packetData(pData),
    .statusStrobe(sStb), .statusCode(sCode),
    .packetCount(cPkt), .badMagicCount(cMag), .badSizeCount(cSize),
    .indexBitmap(bmap));

  int nvec = 0, nerr = 0;
  int nStat = 0, nPkt = 0;
  bit gapsOn = 0;

  // Strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (sStb) nStat = nStat + 1;
      if (pStb) nPkt  = nPkt + 1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mkhdr(input logic [15:0] magic, input logic [4:0] idx);
    return {magic, 1'b0, idx, 10'h000};
  endfunction

  task automatic beat(input logic [31:0] d, input logic l);
    if (gapsOn)
      while ($urandom_range(0, 1) == 0) begin
        tvalid = 1'b0;
        @(posedge clk); #1;
      end
    tdata = d; tlast = l; tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int nd, input logic [31:0] base);
    beat(hdr, nd == 0);
    for (int i = 0; i < nd; i++) beat(base + 32'(i), i == nd - 1);
    idle(3);
  endtask

  task automatic fa_pulse();
    fa = 1'b1; @(posedge clk); #1; fa = 1'b0;
  endtask

  typedef struct {
    logic [31:0] hdr;
    int          nd;
    logic [31:0] base;
    logic [1:0]  code;
    bit          good;
    logic [4:0]  idx;
  } vec_t;

  vec_t vecs[11];

  logic [95:0] expData = '0;
  logic [4:0]  expIdx  = '0;
  logic [15:0] expPkt = 0, expMag = 0, expSize = 0;
  logic [31:0] expBm = 0;

  initial begin
    int s0, p0;
    vecs[0]  = '{mkhdr(16'hA5BE, 5'd1),  3, 32'h1000_0000, 2'd0, 1'b1, 5'd1};
    vecs[1]  = '{mkhdr(16'hA5BE, 5'd2),  3, 32'h2000_0000, 2'd0, 1'b1, 5'd2};
    vecs[2]  = '{mkhdr(16'hA5BE, 5'd3),  3, 32'h3000_0000, 2'd0, 1'b1, 5'd3};
    vecs[3]  = '{mkhdr(16'h1234, 5'd6),  3, 32'hDEAD_0000, 2'd1, 1'b0, 5'd0};
    vecs[4]  = '{mkhdr(16'hA5BE, 5'd4),  3, 32'h4000_0000, 2'd0, 1'b1, 5'd4};
    vecs[5]  = '{mkhdr(16'hA5BE, 5'd8),  1, 32'hBAD0_0000, 2'd2, 1'b0, 5'd0};
    vecs[6]  = '{mkhdr(16'hA5BE, 5'd9),  5, 32'hBAD1_0000, 2'd3, 1'b0, 5'd0};
    vecs[7]  = '{mkhdr(16'hA5BE, 5'd5),  3, 32'h5000_0000, 2'd0, 1'b1, 5'd5};
    vecs[8]  = '{mkhdr(16'hA5BE, 5'd10), 0, 32'h0,         2'd2, 1'b0, 5'd0};
    vecs[9]  = '{mkhdr(16'h0000, 5'd11), 0, 32'h0,         2'd1, 1'b0, 5'd0};
    vecs[10] = '{mkhdr(16'hA5BE, 5'd7),  3, 32'h7000_0000, 2'd0, 1'b1, 5'd7};

    rst = 1'b1; chUp = 1'b0; fa = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;
    idle(3);
    @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_pstb",   pStb, 0);
    chk("rst_sstb",   sStb, 0);
    chk("rst_code",   sCode, 0);
    chk("rst_data",   pData, 0);
    chk("rst_cnts",   {cPkt, cMag, cSize}, 0);
    chk("rst_bmap",   bmap, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    chUp = 1'b1;
    idle(1);
    chk("up_tready", tready, 1);

    foreach (vecs[k]) begin
      s0 = nStat; p0 = nPkt;
      send_pkt(vecs[k].hdr, vecs[k].nd, vecs[k].base);
      if (vecs[k].good) begin
        expPkt++;
        expIdx  = vecs[k].idx;
        expData = {vecs[k].base + 32'd2, vecs[k].base + 32'd1, vecs[k].base};
        expBm[vecs[k].idx] = 1'b1;
      end else if (vecs[k].code == 2'd1) expMag++;
      else expSize++;
      chk($sformatf("v%0d_nstat", k), 128'(nStat - s0), 1);
      chk($sformatf("v%0d_npkt", k),  128'(nPkt - p0), 128'(vecs[k].good));
      chk($sformatf("v%0d_code", k),  sCode, vecs[k].code);
      chk($sformatf("v%0d_idx", k),   pIdx, expIdx);
      chk($sformatf("v%0d_data", k),  pData, expData);
      chk($sformatf("v%0d_cnts", k),  {cPkt, cMag, cSize}, {expPkt, expMag, expSize});
    end

    // FA strobe publishes the cycle's indices and starts a fresh accumulation.
    fa_pulse();
    chk("fa1_bmap", bmap, expBm);
    expBm = 32'h8000_0001;
    gapsOn = 1;
    s0 = nStat; p0 = nPkt;
    send_pkt(mkhdr(16'hA5BE, 5'd0),  3, 32'hA000_0000);
    send_pkt(mkhdr(16'hA5BE, 5'd31), 3, 32'hB000_0000);
    gapsOn = 0;
    expPkt += 2;
    chk("gap_npkt", 128'(nPkt - p0), 2);
    chk("gap_nstat", 128'(nStat - s0), 2);
    chk("gap_idx", pIdx, 5'd31);
    chk("gap_data", pData, {32'hB000_0002, 32'hB000_0001, 32'hB000_0000});
    chk("fa2_hold", bmap, 32'h0000_00BE);
    fa_pulse();
    chk("fa2_bmap", bmap, expBm);
    fa_pulse();
    chk("fa3_empty", bmap, 0);

    // Link drop mid-packet: partial packet vanishes, beats while down are ignored.
    s0 = nStat; p0 = nPkt;
    beat(mkhdr(16'hA5BE, 5'd9), 1'b0);
    beat(32'hCCCC_0000, 1'b0);
    chUp = 1'b0;
    idle(1);
    chk("drop_tready", tready, 0);
    beat(mkhdr(16'h4321, 5'd1), 1'b1);
    idle(2);
    chk("drop_nstat", 128'(nStat - s0), 0);
    chUp = 1'b1;
    idle(1);
    send_pkt(mkhdr(16'hA5BE, 5'd12), 3, 32'hC000_0000);
    expPkt++;
    chk("drop_nstat2", 128'(nStat - s0), 1);
    chk("drop_npkt", 128'(nPkt - p0), 1);
    chk("drop_code", sCode, 0);
    chk("drop_idx", pIdx, 5'd12);
    chk("drop_data", pData, {32'hC000_0002, 32'hC000_0001, 32'hC000_0000});
    chk("drop_cnts", {cPkt, cMag, cSize}, {expPkt, expMag, expSize});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
